// File: rtl/mips_ctrl_pipe.sv
// Pipelined control unit: decodes ID into a control bundle carried through ID/EX, EX/MEM, MEM/WB,
// with load-use stall, EX-branch flush and EX-stage forwarding selects.
module mips_ctrl_pipe #(
   parameter int REG_AW       = 5,
   parameter int LINK_REG     = 31,
   parameter bit EN_IMM_LOGIC = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [31:0]       id_instr,
   input  logic              ex_flush,
   output logic              stall,
   output logic              id_jump,
   output logic              id_illegal,
   output logic              ex_alusrc,
   output logic              ex_branch,
   output logic              ex_bne,
   output logic              ex_link,
   output logic [2:0]        ex_aluop,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              mem_memread,
   output logic              mem_memwrite,
   output logic              wb_regwrite,
   output logic              wb_memtoreg,
   output logic              wb_link,
   output logic [REG_AW-1:0] wb_dst
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_SLTI = 6'b001010;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;
   localparam logic [2:0] ALU_SLT   = 3'b101;

   typedef struct packed {
      logic              alusrc;
      logic              branch;
      logic              bne;
      logic              link;
      logic [2:0]        aluop;
      logic              memread;
      logic              memwrite;
      logic              regwrite;
      logic              memtoreg;
      logic [REG_AW-1:0] dst;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
   } ctl_t;

   logic [5:0]        op;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [REG_AW-1:0] id_rd;
   logic              legal;
   logic              is_jump;
   logic              uses_rs;
   logic              uses_rt;
   logic              hazard;
   ctl_t              dec;
   ctl_t              id_ex_d;
   ctl_t              ex_q;

   // EX/MEM stage state not exposed as ports
   logic              mem_regwrite;
   logic              mem_memtoreg;
   logic              mem_link;
   logic [REG_AW-1:0] mem_dst;

   // low 11 bits (shamt/funct/imm) are the datapath's business
   logic              unused_instr;
   assign unused_instr = ^id_instr;

   assign op    = id_instr[31:26];
   assign id_rs = id_instr[21 +: REG_AW];
   assign id_rt = id_instr[16 +: REG_AW];
   assign id_rd = id_instr[11 +: REG_AW];

   always_comb begin
      dec     = '0;
      legal   = 1'b0;
      is_jump = 1'b0;
      dec.rs  = id_rs;
      dec.rt  = id_rt;
      case (op)
         OP_R: begin
            legal        = 1'b1;
            dec.dst      = id_rd;
            dec.aluop    = ALU_FUNCT;
            dec.regwrite = 1'b1;
         end
         OP_LW: begin
            legal        = 1'b1;
            dec.dst      = id_rt;
            dec.alusrc   = 1'b1;
            dec.aluop    = ALU_ADD;
            dec.memread  = 1'b1;
            dec.memtoreg = 1'b1;
            dec.regwrite = 1'b1;
         end
         OP_SW: begin
            legal        = 1'b1;
            dec.alusrc   = 1'b1;
            dec.aluop    = ALU_ADD;
            dec.memwrite = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            legal        = 1'b1;
            dec.branch   = 1'b1;
            dec.bne      = (op == OP_BNE);
            dec.aluop    = ALU_SUB;
         end
         OP_J: begin
            legal        = 1'b1;
            is_jump      = 1'b1;
         end
         OP_JAL: begin
            legal        = 1'b1;
            is_jump      = 1'b1;
            dec.link     = 1'b1;
            dec.dst      = REG_AW'(LINK_REG);
            dec.regwrite = 1'b1;
         end
         OP_ADDI: begin
            legal        = 1'b1;
            dec.dst      = id_rt;
            dec.alusrc   = 1'b1;
            dec.aluop    = ALU_ADD;
            dec.regwrite = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_SLTI: begin
            if (EN_IMM_LOGIC) begin
               legal        = 1'b1;
               dec.dst      = id_rt;
               dec.alusrc   = 1'b1;
               dec.regwrite = 1'b1;
               dec.aluop    = (op == OP_ANDI) ? ALU_AND :
                              (op == OP_ORI)  ? ALU_OR  : ALU_SLT;
            end
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

   assign uses_rs = (op != OP_J) && (op != OP_JAL);
   assign uses_rt = (op == OP_R) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);

   assign hazard = ex_q.memread && (ex_q.dst != '0) && id_valid &&
                   ((uses_rs && (ex_q.dst == id_rs)) || (uses_rt && (ex_q.dst == id_rt)));

   // flush outranks stall: the squashed instruction must not hold the front end
   assign stall      = hazard && !ex_flush;
   assign id_jump    = is_jump && id_valid && !ex_flush;
   assign id_illegal = id_valid && !legal;

   always_comb begin
      id_ex_d = dec;
      if (!id_valid || ex_flush || !legal || hazard) begin
         id_ex_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q         <= '0;
         mem_memread  <= 1'b0;
         mem_memwrite <= 1'b0;
         mem_regwrite <= 1'b0;
         mem_memtoreg <= 1'b0;
         mem_link     <= 1'b0;
         mem_dst      <= '0;
         wb_regwrite  <= 1'b0;
         wb_memtoreg  <= 1'b0;
         wb_link      <= 1'b0;
         wb_dst       <= '0;
      end else begin
         ex_q         <= id_ex_d;
         mem_memread  <= ex_q.memread;
         mem_memwrite <= ex_q.memwrite;
         mem_regwrite <= ex_q.regwrite;
         mem_memtoreg <= ex_q.memtoreg;
         mem_link     <= ex_q.link;
         mem_dst      <= ex_q.dst;
         wb_regwrite  <= mem_regwrite;
         wb_memtoreg  <= mem_memtoreg;
         wb_link      <= mem_link;
         wb_dst       <= mem_dst;
      end
   end

   assign ex_alusrc = ex_q.alusrc;
   assign ex_branch = ex_q.branch;
   assign ex_bne    = ex_q.bne;
   assign ex_link   = ex_q.link;
   assign ex_aluop  = ex_q.aluop;

   // EX/MEM is the younger result, so it wins over MEM/WB; $0 is never forwarded
   always_comb begin
      fwd_a = 2'b00;
      if (mem_regwrite && (mem_dst != '0) && (mem_dst == ex_q.rs)) begin
         fwd_a = 2'b10;
      end else if (wb_regwrite && (wb_dst != '0) && (wb_dst == ex_q.rs)) begin
         fwd_a = 2'b01;
      end
   end

   always_comb begin
      fwd_b = 2'b00;
      if (mem_regwrite && (mem_dst != '0) && (mem_dst == ex_q.rt)) begin
         fwd_b = 2'b10;
      end else if (wb_regwrite && (wb_dst != '0) && (wb_dst == ex_q.rt)) begin
         fwd_b = 2'b01;
      end
   end

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// Bench for mips_ctrl_pipe: directed steps plus random instruction stream against a stage-list model.
module tb_mips_ctrl_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [31:0] id_instr;
   logic        ex_flush;
   logic        stall, id_jump, id_illegal;
   logic        ex_alusrc, ex_branch, ex_bne, ex_link;
   logic [2:0]  ex_aluop;
   logic [1:0]  fwd_a, fwd_b;
   logic        mem_memread, mem_memwrite;
   logic        wb_regwrite, wb_memtoreg, wb_link;
   logic [4:0]  wb_dst;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mips_ctrl_pipe dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr), .ex_flush(ex_flush),
      .stall(stall), .id_jump(id_jump), .id_illegal(id_illegal),
      .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_bne(ex_bne), .ex_link(ex_link),
      .ex_aluop(ex_aluop), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
      .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_link(wb_link), .wb_dst(wb_dst)
   );

   typedef struct packed {
      logic       legal;
      logic       alusrc, branch, bne, link;
      logic       memread, memwrite, regwrite, memtoreg;
      logic [2:0] aluop;
      logic [4:0] dst, rs, rt;
   } ctl_t;

   ctl_t m_ex, m_mem, m_wb;
   logic       s_stall, s_jump, s_ill;
   logic [1:0] s_fwd_a, s_fwd_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Instruction semantics straight from the opcode table
   function automatic ctl_t decode(input logic [31:0] ins);
      ctl_t c = '0;
      logic [5:0] op = ins[31:26];
      c.rs = ins[25:21];
      c.rt = ins[20:16];
      c.legal = 1'b1;
      if (op == 6'h00) begin c.dst = ins[15:11]; c.aluop = 3'd2; c.regwrite = 1; end
      else if (op == 6'h23) begin c.dst = ins[20:16]; c.alusrc = 1; c.memread = 1; c.memtoreg = 1; c.regwrite = 1; end
      else if (op == 6'h2B) begin c.alusrc = 1; c.memwrite = 1; end
      else if (op == 6'h04 || op == 6'h05) begin c.branch = 1; c.bne = (op == 6'h05); c.aluop = 3'd1; end
      else if (op == 6'h02) begin end
      else if (op == 6'h03) begin c.link = 1; c.dst = 5'd31; c.regwrite = 1; end
      else if (op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h0A) begin
         c.dst = ins[20:16]; c.alusrc = 1; c.regwrite = 1;
         c.aluop = (op == 6'h08) ? 3'd0 : (op == 6'h0C) ? 3'd3 : (op == 6'h0D) ? 3'd4 : 3'd5;
      end
      else c = '0;
      return c;
   endfunction

   function automatic logic [1:0] fwd_model(input logic [4:0] src);
      if (m_mem.regwrite && m_mem.dst != 0 && m_mem.dst == src) return 2'b10;
      if (m_wb.regwrite && m_wb.dst != 0 && m_wb.dst == src) return 2'b01;
      return 2'b00;
   endfunction

   task automatic chk_regs();
      chk("ex_alusrc", 32'(ex_alusrc), 32'(m_ex.alusrc));
      chk("ex_branch", 32'(ex_branch), 32'(m_ex.branch));
      chk("ex_bne", 32'(ex_bne), 32'(m_ex.bne));
      chk("ex_link", 32'(ex_link), 32'(m_ex.link));
      chk("ex_aluop", 32'(ex_aluop), 32'(m_ex.aluop));
      chk("mem_memread", 32'(mem_memread), 32'(m_mem.memread));
      chk("mem_memwrite", 32'(mem_memwrite), 32'(m_mem.memwrite));
      chk("wb_regwrite", 32'(wb_regwrite), 32'(m_wb.regwrite));
      chk("wb_memtoreg", 32'(wb_memtoreg), 32'(m_wb.memtoreg));
      chk("wb_link", 32'(wb_link), 32'(m_wb.link));
      chk("wb_dst", 32'(wb_dst), 32'(m_wb.dst));
   endtask

   // Called at posedge+1: drive, check combinational outputs mid-cycle, clock, check registers
   task automatic step(input logic v, input logic [31:0] ins, input logic fl);
      ctl_t d;
      logic hz, use_rs, use_rt;
      logic [5:0] op = ins[31:26];
      id_valid = v; id_instr = ins; ex_flush = fl;
      #4;
      d = decode(ins);
      use_rs = !(op == 6'h02 || op == 6'h03);
      use_rt = (op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05);
      hz = v && m_ex.memread && m_ex.dst != 0 &&
           ((use_rs && m_ex.dst == ins[25:21]) || (use_rt && m_ex.dst == ins[20:16]));
      chk("stall", 32'(stall), 32'(hz && !fl));
      chk("id_jump", 32'(id_jump), 32'(v && !fl && (op == 6'h02 || op == 6'h03)));
      chk("id_illegal", 32'(id_illegal), 32'(v && !d.legal));
      chk("fwd_a", 32'(fwd_a), 32'(fwd_model(m_ex.rs)));
      chk("fwd_b", 32'(fwd_b), 32'(fwd_model(m_ex.rt)));
      s_stall = stall; s_jump = id_jump; s_ill = id_illegal; s_fwd_a = fwd_a; s_fwd_b = fwd_b;
      @(posedge clk);
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (!v || fl || !d.legal || hz) ? '0 : d;
      #1;
      chk_regs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0);
   endtask

   localparam logic [31:0] ADD3  = 32'h00221820; // add $3,$1,$2
   localparam logic [31:0] LW5   = 32'h8C250000; // lw $5,0($1)
   localparam logic [31:0] ADD6  = 32'h00A23020; // add $6,$5,$2
   localparam logic [31:0] ADDI4 = 32'h20040007; // addi $4,$0,7
   localparam logic [31:0] ORI7  = 32'h34870001; // ori $7,$4,1
   localparam logic [31:0] ADDI0 = 32'h20000007; // addi $0,$0,7
   localparam logic [31:0] ORI0  = 32'h34070001; // ori $7,$0,1
   localparam logic [31:0] JAL   = 32'h0C000010;
   localparam logic [31:0] ILL   = 32'hFC000000;

   logic [5:0] ops [13] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03,
                            6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h3F, 6'h11};

   initial begin
      m_ex = '0; m_mem = '0; m_wb = '0;
      reset = 1'b1; id_valid = 1'($urandom); id_instr = $urandom; ex_flush = 1'($urandom);
      #2;
      chk_regs();
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_fwd", 32'({fwd_a, fwd_b}), 32'd0);
      @(posedge clk); #1;
      chk_regs();
      @(negedge clk);
      reset = 1'b0; id_valid = 1'b0;
      @(posedge clk); #1;
      chk_regs();

      step(1'b1, ADD3, 1'b0);
      chk("add_ex_aluop", 32'(ex_aluop), 32'd2);
      chk("add_ex_alusrc", 32'(ex_alusrc), 32'd0);
      idle(2);
      chk("add_wb", 32'({wb_regwrite, wb_memtoreg, wb_dst}), 32'({1'b1, 1'b0, 5'd3}));

      step(1'b1, LW5, 1'b0);
      step(1'b1, ADD6, 1'b0);
      chk("lu_stall", 32'(s_stall), 32'd1);
      chk("lu_bubble", 32'({ex_alusrc, ex_branch, ex_bne, ex_link, ex_aluop}), 32'd0);
      step(1'b1, ADD6, 1'b0);
      chk("lu_stall_once", 32'(s_stall), 32'd0);
      step(1'b0, 32'h0, 1'b0);
      chk("lu_fwd_a", 32'(s_fwd_a), 32'd1);
      idle(2);

      step(1'b1, ADDI4, 1'b0);
      step(1'b1, ORI7, 1'b0);
      chk("ori_aluop", 32'(ex_aluop), 32'd4);
      step(1'b0, 32'h0, 1'b0);
      chk("ori_fwd_a", 32'(s_fwd_a), 32'd2);
      step(1'b1, ADDI0, 1'b0);
      step(1'b1, ORI0, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      chk("ori_r0_fwd_a", 32'(s_fwd_a), 32'd0);
      idle(2);

      step(1'b1, JAL, 1'b0);
      chk("jal_jump", 32'(s_jump), 32'd1);
      idle(2);
      chk("jal_wb", 32'({wb_regwrite, wb_link, wb_dst}), 32'({1'b1, 1'b1, 5'd31}));

      step(1'b1, LW5, 1'b0);
      step(1'b1, ADD6, 1'b1);
      chk("flush_stall", 32'(s_stall), 32'd0);
      chk("flush_bubble", 32'({ex_alusrc, ex_branch, ex_bne, ex_link, ex_aluop}), 32'd0);
      idle(2);

      step(1'b1, ILL, 1'b0);
      chk("ill_flag", 32'(s_ill), 32'd1);
      step(1'b0, 32'h0, 1'b0);
      chk("ill_mem", 32'({mem_memwrite, mem_memread}), 32'd0);
      step(1'b0, 32'h0, 1'b0);
      chk("ill_wb", 32'(wb_regwrite), 32'd0);
      idle(1);

      // reset arriving while a load-use stall is pending
      step(1'b1, LW5, 1'b0);
      id_valid = 1'b1; id_instr = ADD6; ex_flush = 1'b0;
      #2;
      chk("pre_rst_stall", 32'(stall), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_stall", 32'(stall), 32'd0);
      m_ex = '0; m_mem = '0; m_wb = '0;
      chk_regs();
      id_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk_regs();

      for (int i = 0; i < 400; i++) begin
         logic [31:0] ins;
         ins = {ops[$urandom_range(0, 12)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 11'($urandom)};
         step($urandom_range(0, 99) < 85, ins, $urandom_range(0, 99) < 10);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mips_ctrl_pipe.md
# mips_ctrl_pipe

Parametrised pipelined control unit for the 5-stage MIPS core. It decodes the instruction in ID into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards (stall and bubble), applies EX-stage branch flushes, and generates EX-stage forwarding selects. It replaces the purely combinational opcode decoder and sits beside the datapath pipeline registers.

## Interface
Parameters:
- REG_AW, 5, register-address width
- LINK_REG, 31, destination register for JAL
- EN_IMM_LOGIC, 1, when 1 decode andi/ori/slti; when 0 treat them as illegal

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all pipeline control state
- id_valid  in  1  ID holds a real instruction
- id_instr  in  32  ID instruction; opcode [31:26], rs [25:21], rt [20:16], rd [15:11] (low REG_AW bits of each field used)
- ex_flush  in  1  branch taken in EX; squash the ID instruction
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- id_jump  out  1  ID holds j/jal (combinational, gated by id_valid and ex_flush)
- id_illegal  out  1  ID opcode unsupported, id_valid=1 (combinational)
- ex_alusrc, ex_branch, ex_bne, ex_link  out  1 each  EX controls
- ex_aluop  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
- fwd_a, fwd_b  out  2 each  operand select for rs/rt: 00 regfile, 01 MEM/WB, 10 EX/MEM
- mem_memread, mem_memwrite  out  1 each  MEM controls
- wb_regwrite, wb_memtoreg, wb_link  out  1 each  WB controls
- wb_dst  out  REG_AW  WB write address

## Operation

**Decode, by opcode:**
- R 000000: dst=rd, aluop 010, regwrite.
- lw 100011: dst=rt, alusrc, aluop 000, memread, memtoreg, regwrite.
- sw 101011: alusrc, aluop 000, memwrite; no dst.
- beq 000100: branch, aluop 001. bne 000101: same as beq plus bne.
- j 000010: jump.
- jal 000011: jump, link, dst=LINK_REG, regwrite.
- addi 001000: dst=rt, alusrc, aluop 000, regwrite.
- andi 001100: aluop 011; ori 001101: aluop 100; slti 001010: aluop 101. Each also sets dst=rt, alusrc, regwrite.

**Operand use:**
- uses_rs for every opcode except j and jal.
- uses_rt for R-type, sw, beq and bne.

**Bubbles:**
- Illegal opcode, id_valid=0 and ex_flush=1 each produce an all-zero bundle with dst=0.
- A bubble never writes, never accesses memory and never branches.

**Load-use hazard:**
- hazard = ex_memread & ex_dst≠0 & ((uses_rs & ex_dst==rs) | (uses_rt & ex_dst==rt)) & id_valid.
- ex_memread and ex_dst are internal ID/EX state.
- stall = hazard & ~ex_flush.
- On stall, ID/EX loads a bubble. IF/ID is held externally, so the same instruction is re-decoded next cycle.

**Flush:**
- ex_flush takes priority over stall: ID/EX loads a bubble and stall=0.
- The EX instruction itself proceeds into EX/MEM unchanged.

**Forwarding** (rs shown; rt identical, producing fwd_b):
- fwd_a = 10 if mem_regwrite & mem_dst≠0 & mem_dst==ex_rs.
- Otherwise fwd_a = 01 if wb_regwrite & wb_dst≠0 & wb_dst==ex_rs.
- Otherwise fwd_a = 00.
- EX/MEM wins over MEM/WB.
- Register 0 is never forwarded.

**Pipeline shifting:**
- EX/MEM and MEM/WB shift unconditionally every cycle.
- Stall and flush affect only the ID/EX load.

## Timing
- Reset (async assert; sync release is the system's responsibility) clears every stage register, so every registered output is 0 and wb_dst=0.
- With no other activity after reset, fwd_a/fwd_b=00 and stall=0.
- An instruction decoded in cycle n shows:
  - its ex_* controls in n+1;
  - mem_* in n+2;
  - wb_* in n+3.
- stall, id_jump, id_illegal, fwd_a and fwd_b are combinational; all other outputs are registered.
- A load-use pair costs exactly 1 stall cycle; the consumer then receives the load data via fwd=01.
- A back-to-back ALU dependency costs 0 cycles via fwd=10.
- If reset is asserted mid-stall, the pipe clears and stall=0 at once.

## Test plan
- Reset with random inputs applied: all registered outputs 0; stall=0; fwd=00.
- add $3,$1,$2 (0x00221820) in cycle 0:
  - cycle 1: ex_aluop=010, ex_alusrc=0;
  - cycle 3: wb_regwrite=1, wb_dst=3, wb_memtoreg=0.
- lw $5,0($1) then add $6,$5,$2:
  - stall=1 for exactly one cycle, with an ID/EX bubble (ex_* all 0);
  - the add then reaches EX with fwd_a=01.
- addi $4,$0,7 then ori $7,$4,1: the ori in EX has fwd_a=10 and ex_aluop=100. Repeat with dst $0: fwd_a=00.
- jal 0x0000040 (0x0C000010): id_jump=1; 3 cycles later wb_regwrite=1, wb_link=1, wb_dst=31.
- lw hazard coincident with ex_flush=1: stall=0 and ID/EX is a bubble.
- Opcode 0x3F with id_valid=1: id_illegal=1; no regwrite or memwrite reaches WB or MEM.
